ifu_lsu_mem_arbiter: RTL
========================

Name: ifu_lsu_mem_arbiter

Overview:
- Shares one memory command/response port between the IFU fetch channel (read-only) and the LSU channel (read/write).
- Sits between the IFU/LSU and the ITCM/bus interface unit.
- Tracks outstanding commands in an in-order ID FIFO so each response returns to the requester that issued it.
- Arbitration gives LSU fixed priority, with a starvation guard for IFU.

Parameters:
AW, 32, address width (matches PC_SIZE)
DW, 32, data width (matches XLEN)
OUTS_DEPTH, 2, max outstanding commands (power of 2, >=1)
STARVE_LIM, 4, consecutive IFU-denied cycles before IFU is forced to win (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
ifu_cmd_valid  in  1  IFU fetch request valid
ifu_cmd_ready  out  1  IFU fetch request accepted
ifu_cmd_addr  in  AW  fetch address
ifu_rsp_valid  out  1  fetch response valid
ifu_rsp_ready  in  1  IFU can take response
ifu_rsp_rdata  out  DW  fetched instruction
ifu_rsp_err  out  1  bus error on fetch
lsu_cmd_valid  in  1  LSU request valid
lsu_cmd_ready  out  1  LSU request accepted
lsu_cmd_read  in  1  1=load, 0=store
lsu_cmd_addr  in  AW  load/store address
lsu_cmd_wdata  in  DW  store data
lsu_cmd_wmask  in  DW/8  store byte mask
lsu_rsp_valid  out  1  LSU response valid
lsu_rsp_ready  in  1  LSU can take response
lsu_rsp_rdata  out  DW  load data
lsu_rsp_err  out  1  bus error on load/store
mem_cmd_valid  out  1  command to memory valid
mem_cmd_ready  in  1  memory accepts command
mem_cmd_read  out  1  1=read
mem_cmd_addr  out  AW  address
mem_cmd_wdata  out  DW  write data
mem_cmd_wmask  out  DW/8  write mask
mem_rsp_valid  in  1  memory response valid
mem_rsp_ready  out  1  response accepted
mem_rsp_rdata  in  DW  read data
mem_rsp_err  in  1  error flag
arb_spurious_err  out  1  sticky: response received with no command outstanding

Behaviour:
- All state updates on posedge clk. When rst_n=0: ID FIFO empty (rd/wr ptr 0, count 0), starve counter 0, arb_spurious_err 0.
- Consequence of reset: ifu_rsp_valid=lsu_rsp_valid=0. Commands in flight are forgotten; any mem_rsp arriving afterwards is treated as spurious.
- Command path is combinational, zero latency, no registered grant.
- full = (count==OUTS_DEPTH). No push-while-pop bypass: full blocks new commands even in a cycle where a response pops.
- Grant:
  - sel_ifu = ifu_cmd_valid & (~lsu_cmd_valid | starve_cnt>=STARVE_LIM).
  - sel_lsu = lsu_cmd_valid & ~sel_ifu.
- mem_cmd_valid = (sel_ifu|sel_lsu) & ~full. Mux addr/read/wdata/wmask from the selected requester.
- For an IFU grant: read=1, wdata=0, wmask=0.
- ifu_cmd_ready = sel_ifu & ~full & mem_cmd_ready. lsu_cmd_ready = sel_lsu & ~full & mem_cmd_ready.
- Non-selected requester's ready=0. Requester valid/payload must stay stable until its ready.
- Starve counter (4 bits, saturating at 15):
  - increments when ifu_cmd_valid & ~ifu_cmd_ready;
  - clears on IFU handshake or when ifu_cmd_valid=0.
- ID FIFO:
  - push {id: 0=IFU, 1=LSU} on mem_cmd handshake;
  - pop on mem_rsp handshake;
  - simultaneous push and pop leaves count unchanged;
  - pointers wrap modulo OUTS_DEPTH.
- Response routing, with head = FIFO head id:
  - ifu_rsp_valid = mem_rsp_valid & ~empty & head==0;
  - lsu_rsp_valid = mem_rsp_valid & ~empty & head==1;
  - rdata/err broadcast to both channels.
  - mem_rsp_ready = empty ? 1 : (head ? lsu_rsp_ready : ifu_rsp_ready).
- Spurious response (mem_rsp_valid while empty): accepted and dropped, no requester valid asserted, arb_spurious_err set. It is cleared only by reset.
- Back-pressure: a stalled requester response stalls mem_rsp_ready. Commands may continue until full.
- Ordering: responses are strictly in command-issue order; the memory side must return in order.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all valids=1 and mem_rsp_valid=0 → after release, count=0, ifu/lsu_rsp_valid=0, arb_spurious_err=0, and the first grant goes to LSU.
- Both requesting, mem_cmd_ready=1, immediate in-order responses, STARVE_LIM=4 → LSU granted 4 cycles, IFU granted on the 5th, then the counter clears.
- OUTS_DEPTH=2, mem_rsp_valid=0, issue IFU addr 0x80000000 then LSU addr 0x1000 → third request sees ready=0 (full). Responses 0xAAAA then 0xBBBB route to IFU then LSU.
- Full FIFO with a response popping and a new command valid in the same cycle → command not accepted that cycle, accepted next cycle; count goes 2→1→2.
- LSU response held with lsu_rsp_ready=0 for 3 cycles → mem_rsp_ready=0 for 3 cycles. IFU commands are still accepted until the FIFO is full.
- mem_rsp_valid=1 with the FIFO empty → mem_rsp_ready=1, no rsp_valid asserted, arb_spurious_err=1 and held until rst_n=0.

Source files
------------

// File: rtl/ifu_lsu_mem_arbiter.sv
// Shares one memory command/response port between the IFU fetch channel and the LSU channel.
// LSU has fixed priority with an IFU starvation guard; an in-order ID FIFO routes each response back.
module ifu_lsu_mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int OUTS_DEPTH = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ifu_cmd_valid,
   output logic            ifu_cmd_ready,
   input  logic [AW-1:0]   ifu_cmd_addr,
   output logic            ifu_rsp_valid,
   input  logic            ifu_rsp_ready,
   output logic [DW-1:0]   ifu_rsp_rdata,
   output logic            ifu_rsp_err,
   input  logic            lsu_cmd_valid,
   output logic            lsu_cmd_ready,
   input  logic            lsu_cmd_read,
   input  logic [AW-1:0]   lsu_cmd_addr,
   input  logic [DW-1:0]   lsu_cmd_wdata,
   input  logic [DW/8-1:0] lsu_cmd_wmask,
   output logic            lsu_rsp_valid,
   input  logic            lsu_rsp_ready,
   output logic [DW-1:0]   lsu_rsp_rdata,
   output logic            lsu_rsp_err,
   output logic            mem_cmd_valid,
   input  logic            mem_cmd_ready,
   output logic            mem_cmd_read,
   output logic [AW-1:0]   mem_cmd_addr,
   output logic [DW-1:0]   mem_cmd_wdata,
   output logic [DW/8-1:0] mem_cmd_wmask,
   input  logic            mem_rsp_valid,
   output logic            mem_rsp_ready,
   input  logic [DW-1:0]   mem_rsp_rdata,
   input  logic            mem_rsp_err,
   output logic            arb_spurious_err
);
   localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
   localparam int CW = $clog2(OUTS_DEPTH + 1);

   logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]         count_reg, count_next;
   logic [3:0]            starve_cnt_reg, starve_cnt_next;
   logic                  spurious_reg, spurious_next;
   logic [OUTS_DEPTH-1:0] id_reg;

   logic full, empty, starve_hit, sel_ifu, sel_lsu;
   logic push, pop, head_lsu;

   assign full       = (count_reg == CW'(OUTS_DEPTH));
   assign empty      = (count_reg == '0);
   assign starve_hit = (starve_cnt_reg >= 4'(STARVE_LIM));
   assign sel_ifu    = ifu_cmd_valid & (~lsu_cmd_valid | starve_hit);
   assign sel_lsu    = lsu_cmd_valid & ~sel_ifu;
   assign head_lsu   = id_reg[rd_ptr_reg];

   always_comb begin
      mem_cmd_valid = (sel_ifu | sel_lsu) & ~full;
      ifu_cmd_ready = sel_ifu & ~full & mem_cmd_ready;
      lsu_cmd_ready = sel_lsu & ~full & mem_cmd_ready;
      mem_cmd_read  = 1'b1;
      mem_cmd_addr  = ifu_cmd_addr;
      mem_cmd_wdata = '0;
      mem_cmd_wmask = '0;
      if (!sel_ifu) begin
         mem_cmd_read  = lsu_cmd_read;
         mem_cmd_addr  = lsu_cmd_addr;
         mem_cmd_wdata = lsu_cmd_wdata;
         mem_cmd_wmask = lsu_cmd_wmask;
      end
   end

   // An empty FIFO means nothing is owed: swallow the beat so the bus never wedges.
   always_comb begin
      ifu_rsp_valid = mem_rsp_valid & ~empty & ~head_lsu;
      lsu_rsp_valid = mem_rsp_valid & ~empty & head_lsu;
      ifu_rsp_rdata = mem_rsp_rdata;
      lsu_rsp_rdata = mem_rsp_rdata;
      ifu_rsp_err   = mem_rsp_err;
      lsu_rsp_err   = mem_rsp_err;
      mem_rsp_ready = empty ? 1'b1 : (head_lsu ? lsu_rsp_ready : ifu_rsp_ready);
   end

   assign push = mem_cmd_valid & mem_cmd_ready;
   assign pop  = mem_rsp_valid & mem_rsp_ready & ~empty;
   assign arb_spurious_err = spurious_reg;

   always_comb begin
      wr_ptr_next     = wr_ptr_reg;
      rd_ptr_next     = rd_ptr_reg;
      count_next      = count_reg;
      starve_cnt_next = starve_cnt_reg;
      spurious_next   = spurious_reg | (mem_rsp_valid & empty);
      if (push)
         wr_ptr_next = (wr_ptr_reg == PW'(OUTS_DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      if (pop)
         rd_ptr_next = (rd_ptr_reg == PW'(OUTS_DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      if (push && !pop)
         count_next = count_reg + CW'(1);
      else if (pop && !push)
         count_next = count_reg - CW'(1);
      if (!ifu_cmd_valid || ifu_cmd_ready)
         starve_cnt_next = '0;
      else if (starve_cnt_reg != 4'hF)
         starve_cnt_next = starve_cnt_reg + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         starve_cnt_reg <= '0;
         spurious_reg   <= 1'b0;
      end else begin
         wr_ptr_reg     <= wr_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         count_reg      <= count_next;
         starve_cnt_reg <= starve_cnt_next;
         spurious_reg   <= spurious_next;
      end
   end

   // Requester id per slot: 0 = IFU, 1 = LSU.
   generate
      for (genvar gi = 0; gi < OUTS_DEPTH; gi++) begin : g_id
         always_ff @(posedge clk) begin
            if (!rst_n)
               id_reg[gi] <= 1'b0;
            else if (push && wr_ptr_reg == PW'(gi))
               id_reg[gi] <= ~sel_ifu;
         end
      end
   endgenerate
endmodule
